// File: rtl/reg_file_read_unit.sv
// Read side of the register bank: two-operand reads over a valid/ready handshake with a
// single registered output stage, plus a sequential dump engine that streams every register.
// Optional same-cycle write bypass is compiled in with `define READ_BYPASS_EN.
module reg_file_read_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*WIDTH-1:0]  regs_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_W-1:0]          rs1_i,
  input  logic [ADDR_W-1:0]          rs2_i,
  output logic [WIDTH-1:0]           rd_data1_o,
  output logic [WIDTH-1:0]           rd_data2_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  input  logic                       Reg_Write_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [WIDTH-1:0]           Rd,
  input  logic                       dump_start_i,
  output logic                       dump_valid_o,
  input  logic                       dump_ready_i,
  output logic [ADDR_W-1:0]          dump_idx_o,
  output logic [WIDTH-1:0]           dump_data_o,
  output logic                       dump_busy_o
);

  typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
  logic [WIDTH-1:0]  dump_data_q, dump_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]  rd_data1_q, rd_data1_d;
  logic [WIDTH-1:0]  rd_data2_q, rd_data2_d;

  logic [WIDTH-1:0]  bank [NUM_REGS];
  logic [WIDTH-1:0]  op1, op2;
  logic              accept;

  // Unflatten the bank; index 0 is forced to zero when it is a hardwired zero register.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      bank[k] = regs_i[k*WIDTH +: WIDTH];
    end
    if (ZERO_REG != 0) begin
      bank[0] = '0;
    end
  end

`ifdef READ_BYPASS_EN
  logic byp_ok;
  assign byp_ok = Reg_Write_i && !((ZERO_REG != 0) && (wr_addr_i == '0));

  // Operand select with same-cycle write forwarding.
  always_comb begin
    op1 = (byp_ok && (wr_addr_i == rs1_i)) ? Rd : bank[rs1_i];
    op2 = (byp_ok && (wr_addr_i == rs2_i)) ? Rd : bank[rs2_i];
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{Reg_Write_i, wr_addr_i, Rd};

  // Operand select straight from the bank (old value on a same-cycle write).
  always_comb begin
    op1 = bank[rs1_i];
    op2 = bank[rs2_i];
  end
`endif

  // Ready is also gated by reset because the idle/empty reset state would otherwise show ready.
  assign req_ready_o = !reset && (state_q == StIdle) && (!rd_valid_q || rd_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  // Output stage: load on accept, empty on drain, otherwise hold.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    if (accept) begin
      rd_valid_d = 1'b1;
      rd_data1_d = op1;
      rd_data2_d = op2;
    end else if (rd_ready_i) begin
      rd_valid_d = 1'b0;
    end
  end

  // Dump FSM next-state: word is registered on entry and on every advance.
  always_comb begin
    state_d     = state_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      StIdle: begin
        if (dump_start_i) begin
          state_d     = StDump;
          dump_idx_d  = '0;
          dump_data_d = bank[0];
        end
      end
      StDump: begin
        if (dump_ready_i) begin
          if (dump_idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_d = StDone;
          end else begin
            dump_idx_d  = dump_idx_q + 1'b1;
            dump_data_d = bank[dump_idx_q + 1'b1];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Dump FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Read output stage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_data1_o   = rd_data1_q;
  assign rd_data2_o   = rd_data2_q;
  assign dump_valid_o = (state_q == StDump);
  assign dump_busy_o  = (state_q == StDump) || (state_q == StDone);
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;

endmodule

// File: tb/tb_reg_file_read_unit.sv
// Directed bench for reg_file_read_unit: read path, stall/throughput, zero register,
// optional write bypass, dump engine and reset mid-dump.
module tb_reg_file_read_unit;

  logic           clk = 1'b0;
  logic           reset;
  logic [1023:0]  regs;
  logic           req_valid, rd_ready, reg_write, dump_start, dump_ready;
  logic [4:0]     rs1, rs2, wr_addr;
  logic [31:0]    rd_wdata;

  logic           req_ready, rd_valid, dump_valid, dump_busy;
  logic [31:0]    rd_data1, rd_data2, dump_data;
  logic [4:0]     dump_idx;

  logic           req_ready_z, rd_valid_z, dump_valid_z, dump_busy_z;
  logic [31:0]    rd_data1_z, rd_data2_z, dump_data_z;
  logic [4:0]     dump_idx_z;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  reg_file_read_unit #(.ZERO_REG(0)) u_dut (
    .clk(clk), .reset(reset), .regs_i(regs),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .rs1_i(rs1), .rs2_i(rs2),
    .rd_data1_o(rd_data1), .rd_data2_o(rd_data2), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .Reg_Write_i(reg_write), .wr_addr_i(wr_addr), .Rd(rd_wdata),
    .dump_start_i(dump_start), .dump_valid_o(dump_valid), .dump_ready_i(dump_ready),
    .dump_idx_o(dump_idx), .dump_data_o(dump_data), .dump_busy_o(dump_busy)
  );

  reg_file_read_unit #(.ZERO_REG(1)) u_dut_z (
    .clk(clk), .reset(reset), .regs_i(regs),
    .req_valid_i(req_valid), .req_ready_o(req_ready_z), .rs1_i(rs1), .rs2_i(rs2),
    .rd_data1_o(rd_data1_z), .rd_data2_o(rd_data2_z), .rd_valid_o(rd_valid_z),
    .rd_ready_i(rd_ready),
    .Reg_Write_i(reg_write), .wr_addr_i(wr_addr), .Rd(rd_wdata),
    .dump_start_i(dump_start), .dump_valid_o(dump_valid_z), .dump_ready_i(dump_ready),
    .dump_idx_o(dump_idx_z), .dump_data_o(dump_data_z), .dump_busy_o(dump_busy_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_reg(input int k, input logic [31:0] v);
    regs[k*32 +: 32] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data1"}, rd_data1, 32'd0);
    chk({tag, "_rd_data2"}, rd_data2, 32'd0);
    chk({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    chk({tag, "_dump_idx"}, 32'(dump_idx), 32'd0);
    chk({tag, "_dump_data"}, dump_data, 32'd0);
    chk({tag, "_dump_busy"}, 32'(dump_busy), 32'd0);
    chk({tag, "_z_req_ready"}, 32'(req_ready_z), 32'd0);
    chk({tag, "_z_dump_valid"}, 32'(dump_valid_z), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; rd_ready = 1; reg_write = 0; dump_start = 0; dump_ready = 0;
    rs1 = 0; rs2 = 0; wr_addr = 0; rd_wdata = 0;
    for (int k = 0; k < 32; k++) set_reg(k, k * 32'h11);
    #1;
    chk_all_zero("reset");

    tick();
    reset = 1'b0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);

    // Basic read, 1-cycle latency.
    req_valid = 1; rs1 = 3; rs2 = 31;
    tick();
    chk("rd1_valid", 32'(rd_valid), 32'd1);
    chk("rd1_data1", rd_data1, 32'h33);
    chk("rd1_data2", rd_data2, 32'h20F);

    // Consumer stalls; new request must wait and outputs must hold.
    rd_ready = 0; rs1 = 1; rs2 = 2;
    #1;
    chk("stall_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(rd_valid), 32'd1);
      chk("stall_data1", rd_data1, 32'h33);
      chk("stall_data2", rd_data2, 32'h20F);
      chk("stall_ready_hold", 32'(req_ready), 32'd0);
    end
    rd_ready = 1;
    #1;
    chk("release_ready", 32'(req_ready), 32'd1);
    tick();
    chk("release_data1", rd_data1, 32'h11);
    chk("release_data2", rd_data2, 32'h22);

    // Back-to-back requests, one result per cycle; rs1==rs2 legal.
    rs1 = 4; rs2 = 5;
    tick();
    chk("b2b1_valid", 32'(rd_valid), 32'd1);
    chk("b2b1_data1", rd_data1, 32'h44);
    chk("b2b1_data2", rd_data2, 32'h55);
    rs1 = 6; rs2 = 6;
    tick();
    chk("b2b2_data1", rd_data1, 32'h66);
    chk("b2b2_data2", rd_data2, 32'h66);

    // Zero register behaviour on both parameterisations.
    set_reg(0, 32'hDEADBEEF); rs1 = 0; rs2 = 0;
    tick();
    chk("zr0_data1", rd_data1, 32'hDEADBEEF);
    chk("zr0_data2", rd_data2, 32'hDEADBEEF);
    chk("zr1_valid", 32'(rd_valid_z), 32'd1);
    chk("zr1_data1", rd_data1_z, 32'd0);
    chk("zr1_data2", rd_data2_z, 32'd0);

    // Same-cycle write to the source index.
    set_reg(5, 32'h1); reg_write = 1; wr_addr = 5; rd_wdata = 32'hABCD; rs1 = 5; rs2 = 7;
    tick();
`ifdef READ_BYPASS_EN
    chk("byp_data1", rd_data1, 32'hABCD);
`else
    chk("byp_data1", rd_data1, 32'h1);
`endif
    chk("byp_data2", rd_data2, 32'h77);

    // Same-cycle write to index 0: never forwarded on the zero-register instance.
    wr_addr = 0; rd_wdata = 32'h1234; rs1 = 0; rs2 = 0;
    tick();
`ifdef READ_BYPASS_EN
    chk("byp0_data1", rd_data1, 32'h1234);
`else
    chk("byp0_data1", rd_data1, 32'hDEADBEEF);
`endif
    chk("byp0_z_data1", rd_data1_z, 32'd0);
    reg_write = 0; req_valid = 0;
    tick();
    chk("drain_valid", 32'(rd_valid), 32'd0);

    // Full dump with ready toggling; a read request waits until IDLE.
    set_reg(0, 32'h0); set_reg(5, 32'h55);
    dump_start = 1;
    tick();
    dump_start = 0; req_valid = 1; rs1 = 2; rs2 = 3;
    for (int k = 0; k < 32; k++) begin
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_idx", 32'(dump_idx), k);
      chk("dump_data", dump_data, k * 32'h11);
      chk("dump_req_ready", 32'(req_ready), 32'd0);
      chk("dump_busy", 32'(dump_busy), 32'd1);
      dump_ready = 0;
      tick();
      chk("dump_idx_hold", 32'(dump_idx), k);
      dump_ready = 1;
      tick();
    end
    chk("done_valid", 32'(dump_valid), 32'd0);
    chk("done_busy", 32'(dump_busy), 32'd1);
    chk("done_req_ready", 32'(req_ready), 32'd0);
    chk("done_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("post_busy", 32'(dump_busy), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("post_rd_valid", 32'(rd_valid), 32'd1);
    chk("post_rd_data1", rd_data1, 32'h22);
    chk("post_rd_data2", rd_data2, 32'h33);
    req_valid = 0; dump_ready = 0;
    tick();

    // Reset in the middle of a dump aborts immediately.
    dump_start = 1;
    tick();
    dump_start = 0; dump_ready = 1;
    repeat (10) tick();
    chk("mid_idx", 32'(dump_idx), 32'd10);
    chk("mid_data", dump_data, 32'hAA);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("abort");
    tick();
    reset = 1'b0;
    #1;
    chk("after_ready", 32'(req_ready), 32'd1);
    chk("after_busy", 32'(dump_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_dump_valid", 32'(dump_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
